// File: rtl/uart_pkg.sv
// Shared UART types and constants for the transmit-side feed logic.
// Latency: none (types and constants only).
// Backpressure: n/a.
`ifndef WORD_SIZE_p
`define WORD_SIZE_p 8
`endif

package uart_pkg;

  // Default number of words buffered ahead of the transmitter.
  localparam int UART_TX_FIFO_DEPTH = 16;

  // Launch sequencer states for feeding the transmitter.
  typedef enum logic [2:0] {
    IDLE,
    WAIT_RDY,
    LAUNCH,
    WAIT_LOW,
    WAIT_DONE
  } tx_feed_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Circular synchronous FIFO: storage array, wrapping pointers, occupancy count, registered full/empty.
// Latency: a pushed word is visible on pop_data one cycle after the push edge.
// Backpressure: push ignored while full, pop ignored while empty; count exported only with UART_TX_FIFO_STATUS_EN.
`ifndef WORD_SIZE_p
`define WORD_SIZE_p 8
`endif

module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int WORD_SIZE = `WORD_SIZE_p,
  parameter int DEPTH     = UART_TX_FIFO_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [WORD_SIZE-1:0] push_data,
  input  logic                 pop,
  output logic [WORD_SIZE-1:0] pop_data,
  output logic                 full,
  output logic                 empty
`ifdef UART_TX_FIFO_STATUS_EN
  ,
  output logic [$clog2(DEPTH):0] level
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = 1;
  localparam logic [PW:0]   CNT_ONE  = 1;
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

  logic [WORD_SIZE-1:0] mem [DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [PW:0]          count;
  logic [PW:0]          count_nxt;
  logic                 do_push;
  logic                 do_pop;

  // Gate against the registered flags so a pop on a full FIFO still blocks that cycle's write.
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

`ifdef UART_TX_FIFO_STATUS_EN
  assign level = count;
`endif

  // Next occupancy: simultaneous push and pop cancel out.
  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop) begin
      count_nxt = count + CNT_ONE;
    end else if (!do_push && do_pop) begin
      count_nxt = count - CNT_ONE;
    end
  end

  // Pointers, count and flags; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      count <= count_nxt;
      full  <= (count_nxt == CNT_FULL);
      empty <= (count_nxt == '0);
    end
  end

  // Storage write; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit buffer feeding a UART transmitter via data_send/tx_send_i/tx_avbl_i; UART_TX_FIFO_STATUS_EN adds level/overflow.
// Latency: write to idle block pops at +1, WAIT_RDY at +2, tx_send_i at +3 earliest.
// Backpressure: writes dropped while full; launches wait on tx_avbl_i; data_send held for the whole frame.
`ifndef WORD_SIZE_p
`define WORD_SIZE_p 8
`endif

module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int WORD_SIZE = `WORD_SIZE_p,
  parameter int DEPTH     = UART_TX_FIFO_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] wr_data,
  input  logic                 wr_en,
  output logic                 full,
  output logic                 empty,
  output logic                 tx_busy,
  output logic [WORD_SIZE-1:0] data_send,
  output logic                 tx_send_i,
  input  logic                 tx_avbl_i
`ifdef UART_TX_FIFO_STATUS_EN
  ,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
`endif
);

  tx_feed_state_t       state;
  tx_feed_state_t       state_nxt;
  logic                 pop;
  logic [WORD_SIZE-1:0] pop_data;

  uart_sync_fifo #(
    .WORD_SIZE (WORD_SIZE),
    .DEPTH     (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (full),
    .empty     (empty)
`ifdef UART_TX_FIFO_STATUS_EN
    ,
    .level     (level)
`endif
  );

  // Launch sequencer state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and handshake outputs; WAIT_LOW masks the pre-launch stale tx_avbl_i high.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    tx_send_i = 1'b0;
    tx_busy   = 1'b1;
    unique case (state)
      IDLE: begin
        tx_busy = 1'b0;
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = WAIT_RDY;
        end
      end
      WAIT_RDY: begin
        if (tx_avbl_i) state_nxt = LAUNCH;
      end
      LAUNCH: begin
        tx_send_i = 1'b1;
        state_nxt = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (!tx_avbl_i) state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (tx_avbl_i) begin
          if (!empty) begin
            pop       = 1'b1;
            state_nxt = WAIT_RDY;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Holding register: only a pop changes the word presented to the transmitter.
  always_ff @(posedge clk) begin
    if (rst)      data_send <= '0;
    else if (pop) data_send <= pop_data;
  end

`ifdef UART_TX_FIFO_STATUS_EN
  // Sticky record of any write attempted against a full FIFO.
  always_ff @(posedge clk) begin
    if (rst)                overflow <= 1'b0;
    else if (wr_en && full) overflow <= 1'b1;
  end
`endif

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Transmit-side buffer that sits directly upstream of the UART transmitter.
- Accepts words from the system side with a write strobe, stores them in a circular FIFO, and launches them one at a time into the transmitter.
- Uses the transmitter's data_send / tx_send_i / tx_avbl_i handshake.
- Holds data_send stable for the entire frame.

Parameters:
- WORD_SIZE, default `WORD_SIZE_p (8): bits per UART word; must equal the transmitter's WORD_SIZE.
- DEPTH, default 16: FIFO entries; power of two, ≥2. Pointers are $clog2(DEPTH) bits.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- wr_data  input  WORD_SIZE  word to queue
- wr_en  input  1  write strobe; word written on rising clk when wr_en=1 and full=0
- full  output  1  FIFO holds DEPTH words
- empty  output  1  FIFO holds 0 words (holding register excluded)
- tx_busy  output  1  a word is pending or in flight to the transmitter
- data_send  output  WORD_SIZE  to transmitter; stable from launch until frame completion
- tx_send_i  output  1  to transmitter; single-cycle launch pulse
- tx_avbl_i  input  1  from transmitter; high = transmitter idle and ready

Behaviour:
- Reset state: wr/rd pointers 0, count 0, full=0, empty=1, tx_busy=0, data_send=0, tx_send_i=0, FSM=IDLE. Reset mid-frame discards all stored words and the holding word. The transmitter is reset by the same rst.
- FIFO write:
  - When wr_en && !full, write mem[wr_ptr] and increment wr_ptr (natural wrap at DEPTH).
  - wr_en while full is dropped; FIFO contents are unchanged.
- FIFO read:
  - Only the FSM pops: mem[rd_ptr] goes into the data_send register and rd_ptr increments.
- Count:
  - Push and pop in the same cycle leaves count unchanged. This is legal when full (pop frees a slot that cycle; write is still blocked by the registered full) and when empty (no pop).
  - full and empty are registered, derived from the next count.
- FSM states:
  - IDLE: tx_busy=0. If !empty, pop into data_send and go to WAIT_RDY (1 cycle).
  - WAIT_RDY: if tx_avbl_i=1, go to LAUNCH.
  - LAUNCH: tx_send_i=1 for exactly this one cycle, then go to WAIT_LOW.
  - WAIT_LOW: ignore tx_avbl_i until it is sampled 0. This masks the stale high from before the launch. Then go to WAIT_DONE.
  - WAIT_DONE: wait for tx_avbl_i=1 (frame complete, transmitter idle).
    - If !empty: pop next word into data_send and go to WAIT_RDY.
    - Else: go to IDLE.
- tx_busy=1 in every state except IDLE.
- data_send changes only on a pop (IDLE or WAIT_DONE exit).
- Latency: first write to an empty, idle block gives pop at +1 cycle, WAIT_RDY at +2, tx_send_i at +3 earliest (given tx_avbl_i=1).
- Back-to-back writes while busy queue in order. Transmission order equals write order.

Optional Feature:
- Macro UART_TX_FIFO_STATUS_EN.
- When defined, adds outputs:
  - level, $clog2(DEPTH)+1 bits: current FIFO count.
  - overflow, 1 bit: sticky, set on wr_en && full, cleared only by rst.
- When undefined, these ports and their logic do not exist. All other behaviour is identical.

Decomposition:
- Shared package uart_pkg:
  - tx_feed_state_t enum {IDLE, WAIT_RDY, LAUNCH, WAIT_LOW, WAIT_DONE}.
  - Default DEPTH constant UART_TX_FIFO_DEPTH.
- WORD_SIZE continues to come from `WORD_SIZE_p.
- One sub-module, uart_sync_fifo: storage array, pointers, count, full/empty, push/pop ports, parameterised WORD_SIZE/DEPTH.
- uart_tx_fifo instantiates it and contains the launch FSM.

Test Plan:
- Reset then idle, tx_avbl_i=1: empty=1, full=0, tx_busy=0, tx_send_i never pulses.
- Write 0xA5, tx_avbl_i=1: tx_send_i single pulse 3 cycles after write with data_send=0xA5; data_send held until tx_avbl_i returns high after ≥1 low cycle.
- Write 0x01..0x04 back-to-back, transmitter attached at a small BAUD_LIMIT: serial line carries 0x01, 0x02, 0x03, 0x04 in order; exactly 4 tx_send_i pulses; tx_busy drops after the last frame.
- DEPTH=16 with tx_avbl_i held 0: write 17 words (after the first has popped, 16 fill the FIFO): full=1; further write dropped; with UART_TX_FIFO_STATUS_EN, overflow=1 and level=16.
- Full FIFO, simultaneous pop and wr_en: pop occurs, write dropped, level=15, full=0 next cycle.
- Assert rst during WAIT_DONE with 5 words queued: next cycle empty=1, tx_busy=0, tx_send_i=0, data_send=0; no further launches.
